// File: rtl/lcd_mode_sched.sv
// Display-mode scheduler: debounced mode button, frame-aligned source switching, inactivity return.
// Optional macro BLANK_FRAME_EN blanks data_char for the frame that follows every switch.
module lcd_mode_sched #(
    parameter int DEB_CNT   = 8,
    parameter int TIMEOUT_S = 30
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en_1hz,
    input  logic       i_en_tick,
    input  logic       i_btn_mode,
    input  logic       i_lock_watch,
    input  logic [4:0] i_index_char,
    input  logic [7:0] i_data_mode0,
    input  logic [7:0] i_data_mode1,
    input  logic [7:0] i_data_mode2,
    output logic [7:0] o_data_char,
    output logic [1:0] o_mode,
    output logic       o_pending,
    output logic       o_set_active
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CNT - 1);
    localparam logic [7:0] TO_MAX   = 8'(TIMEOUT_S);

    function automatic logic [1:0] inc_mod3(input logic [1:0] m);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c >= TO_MAX) ? TO_MAX : c + 8'd1;
    endfunction

    logic       r_btn_s1;
    logic       r_btn_s2;
    logic       r_deb_level;
    logic [7:0] r_deb_cnt;
    logic       r_press;
    logic [4:0] r_idx_prev;
    logic [7:0] r_to_cnt;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_target;
    logic [1:0] w_target_nxt;
    logic [1:0] r_mode;
    logic       r_set_active;
    logic       w_boundary;
    logic       w_press_ok;
    logic       w_expired;
    logic [7:0] w_src_char;

    // Synchroniser and frame-index history carry no control meaning; left unreset.
    always_ff @(posedge i_clk) begin
        r_btn_s1   <= i_btn_mode;
        r_btn_s2   <= r_btn_s1;
        r_idx_prev <= i_index_char;
    end

    // Debounce: count consecutive ticks that disagree with the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_deb_level <= 1'b0;
            r_deb_cnt   <= 8'd0;
            r_press     <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (i_en_tick) begin
                if (r_btn_s2 != r_deb_level) begin
                    if (r_deb_cnt == DEB_LAST) begin
                        r_deb_level <= r_btn_s2;
                        r_deb_cnt   <= 8'd0;
                        r_press     <= r_btn_s2;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + 8'd1;
                    end
                end else begin
                    r_deb_cnt <= 8'd0;
                end
            end
        end
    end

    assign w_boundary = (i_index_char == 5'd0) && (r_idx_prev == 5'd31);
    assign w_press_ok = r_press && !i_lock_watch;
    assign w_expired  = (r_to_cnt == TO_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= 8'd0;
        end else if ((r_state == S_SWITCH) || w_press_ok) begin
            r_to_cnt <= 8'd0;
        end else if (i_en_1hz && (r_mode != 2'd0) && (r_state == S_IDLE) && !i_lock_watch) begin
            r_to_cnt <= sat_inc(r_to_cnt);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_target <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        case (r_state)
            S_IDLE: begin
                if (i_lock_watch && (r_mode != 2'd0)) begin
                    w_state_nxt  = S_PEND;
                    w_target_nxt = 2'd0;
                end else if (w_press_ok) begin
                    w_state_nxt  = S_PEND;
                    w_target_nxt = inc_mod3(r_mode);
                end else if (w_expired && (r_mode != 2'd0)) begin
                    w_state_nxt  = S_PEND;
                    w_target_nxt = 2'd0;
                end
            end
            S_PEND: begin
                if (i_lock_watch && (r_mode == 2'd0)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    // A press coinciding with the boundary is dropped; the old target is taken.
                    if (i_lock_watch) begin
                        w_target_nxt = 2'd0;
                    end else if (w_press_ok && !w_boundary) begin
                        w_target_nxt = inc_mod3(r_target);
                    end
                    if (w_boundary) begin
                        w_state_nxt = S_SWITCH;
                    end
                end
            end
            S_SWITCH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode       <= 2'd0;
            r_set_active <= 1'b0;
        end else if (r_state == S_SWITCH) begin
            r_mode       <= r_target;
            r_set_active <= (r_target == 2'd1);
        end
    end

    always_comb begin
        case (r_mode)
            2'd0:    w_src_char = i_data_mode0;
            2'd1:    w_src_char = i_data_mode1;
            2'd2:    w_src_char = i_data_mode2;
            default: w_src_char = 8'h20;
        endcase
    end

`ifdef BLANK_FRAME_EN
    logic r_blank;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_blank <= 1'b0;
        end else if (r_state == S_SWITCH) begin
            r_blank <= 1'b1;
        end else if (w_boundary) begin
            r_blank <= 1'b0;
        end
    end

    assign o_data_char = r_blank ? 8'h20 : w_src_char;
`else
    assign o_data_char = w_src_char;
`endif

    assign o_mode       = r_mode;
    assign o_pending    = (r_state == S_PEND);
    assign o_set_active = r_set_active;

endmodule
